// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP normalization path.
package sfp_pkg;

    localparam int SFP_DW         = 20;
    localparam int SFP_DIV_CYCLES = 20;
    localparam int SFP_FRAC_DEF   = 8;

    typedef enum logic [2:0] {
        SFP_IDLE  = 3'd0,
        SFP_LOAD  = 3'd1,
        SFP_ISSUE = 3'd2,
        SFP_WAIT  = 3'd3,
        SFP_DONE  = 3'd4
    } sfp_norm_state_t;

endpackage

// File: rtl/sfp_norm_sum.sv
// Combinational adder tree over LANES unsigned elements, zero-extended to DW bits.
module sfp_norm_sum #(
    parameter int LANES  = 8,
    parameter int ELEM_W = 11,
    parameter int DW     = 20
) (
    input  logic [LANES*ELEM_W-1:0] elems_i,
    output logic [DW-1:0]           sum_o
);

    // Heap-indexed tree: node n has children 2n and 2n+1, leaves at LANES..2*LANES-1.
    logic [DW-1:0] node [1:2*LANES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign node[LANES+i] = {{(DW-ELEM_W){1'b0}}, elems_i[i*ELEM_W +: ELEM_W]};
    end

    for (genvar n = 1; n < LANES; n++) begin : g_node
        assign node[n] = node[2*n] + node[2*n+1];
    end

    assign sum_o = node[1];

endmodule

// File: rtl/sfp_norm_ctrl.sv
// Normalization sequencer: sums a vector, then issues one (elem << FRAC) / sum per lane.
// Define SFP_NORM_ROUND_EN for round-to-nearest quotients; truncating otherwise.
module sfp_norm_ctrl
    import sfp_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ELEM_W = 11,
    parameter int FRAC   = SFP_FRAC_DEF,
    parameter int DW     = SFP_DW,
    parameter int OUT_W  = FRAC + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ELEM_W-1:0] in_data,
    output logic                    div_start,
    output logic [DW-1:0]           div_a,
    output logic [DW-1:0]           div_b,
    input  logic                    div_busy,
    input  logic                    div_valid,
    input  logic [DW-1:0]           div_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
`ifdef SFP_NORM_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    sfp_norm_state_t          state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [LANES*ELEM_W-1:0]  elem_q, elem_d;
    logic [DW-1:0]            sum_q, sum_d;
    logic [DW-1:0]            div_a_q, div_a_d;
    logic [DW-1:0]            div_b_q, div_b_d;
    logic [LANES*OUT_W-1:0]   out_q, out_d;
    logic [DW-1:0]            tree_sum;
    logic [DW-1:0]            issue_a;

    function automatic logic [DW-1:0] dividend(input logic [ELEM_W-1:0] e,
                                               input logic [DW-1:0]     s);
        logic [DW-1:0] a;
        a = {{(DW-ELEM_W){1'b0}}, e} << FRAC;
        a = a + (ROUND_EN ? (s >> 1) : '0);
        return a;
    endfunction

    sfp_norm_sum #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W),
        .DW     (DW)
    ) u_sum (
        .elems_i (elem_q),
        .sum_o   (tree_sum)
    );

    assign issue_a = dividend(elem_q[idx_q*ELEM_W +: ELEM_W], sum_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        elem_d  = elem_q;
        sum_d   = sum_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        out_d   = out_q;
        case (state_q)
            SFP_IDLE: begin
                if (in_valid) begin
                    elem_d  = in_data;
                    idx_d   = '0;
                    state_d = SFP_LOAD;
                end
            end
            SFP_LOAD: begin
                sum_d = tree_sum;
                // The divider never answers a zero divisor, so skip straight to an all-zero result.
                if (tree_sum == '0) begin
                    out_d   = '0;
                    state_d = SFP_DONE;
                end else begin
                    state_d = SFP_ISSUE;
                end
            end
            SFP_ISSUE: begin
                div_a_d = issue_a;
                div_b_d = sum_q;
                state_d = SFP_WAIT;
            end
            SFP_WAIT: begin
                if (div_valid && !div_busy) begin
                    out_d[idx_q*OUT_W +: OUT_W] = div_val[OUT_W-1:0];
                    if (idx_q == LAST_IDX) begin
                        state_d = SFP_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SFP_ISSUE;
                    end
                end
            end
            SFP_DONE: begin
                if (out_ready) begin
                    state_d = SFP_IDLE;
                end
            end
            default: state_d = SFP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SFP_IDLE;
            idx_q   <= '0;
            elem_q  <= '0;
            sum_q   <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            sum_q   <= sum_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == SFP_IDLE);
    assign div_start = (state_q == SFP_ISSUE);
    assign div_a     = div_start ? issue_a : div_a_q;
    assign div_b     = div_start ? sum_q   : div_b_q;
    assign out_valid = (state_q == SFP_DONE);
    assign out_data  = out_q;

    // Quotients are bounded by 2^FRAC, so the high divider bits carry nothing.
    logic unused_div_hi;
    assign unused_div_hi = ^div_val[DW-1:OUT_W];

endmodule

// File: tb/tb_sfp_norm_ctrl.sv
// Directed bench for sfp_norm_ctrl with a behavioral 20-cycle divider model.
module tb_sfp_norm_ctrl;

    localparam int LANES  = 8;
    localparam int ELEM_W = 11;
    localparam int FRAC   = 8;
    localparam int DW     = 20;
    localparam int OUT_W  = 9;
    localparam int NVEC   = 6;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [LANES*ELEM_W-1:0] in_data = '0;
    logic                    in_ready, div_start, out_valid;
    logic [DW-1:0]           div_a, div_b;
    logic                    div_busy = 1'b0;
    logic                    div_valid = 1'b0;
    logic [DW-1:0]           div_val = '0;
    logic [LANES*OUT_W-1:0]  out_data;

    int n_chk  = 0;
    int n_fail = 0;

    sfp_norm_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_val   (div_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Divider: busy for 20 cycles after start, then valid (busy low) until the next start.
    int dcnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            div_busy  <= 1'b0;
            div_valid <= 1'b0;
            div_val   <= '0;
            dcnt      <= 0;
        end else if (div_start) begin
            div_busy  <= 1'b1;
            div_valid <= 1'b0;
            div_val   <= (div_b != 0) ? div_a / div_b : '1;
            dcnt      <= 20;
        end else if (div_busy) begin
            if (dcnt == 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
            end
            dcnt <= dcnt - 1;
        end
    end

    int            cyc = 0;
    int            st_t[$];
    logic [DW-1:0] st_a[$];
    logic [DW-1:0] st_b[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) begin
            st_t.push_back(cyc);
            st_a.push_back(div_a);
            st_b.push_back(div_b);
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string                   name;
        logic [LANES*ELEM_W-1:0] e;
        logic [LANES*OUT_W-1:0]  q;
        logic [LANES*OUT_W-1:0]  qr;
        int                      lat;
        int                      nst;
    } vec_t;

    vec_t vt [NVEC];

    task automatic set_vec(input int k, input string nm, input logic [LANES*ELEM_W-1:0] e,
                           input logic [LANES*OUT_W-1:0] q, input logic [LANES*OUT_W-1:0] qr,
                           input int lat, input int nst);
        vt[k].name = nm;
        vt[k].e    = e;
        vt[k].q    = q;
        vt[k].qr   = qr;
        vt[k].lat  = lat;
        vt[k].nst  = nst;
    endtask

    function automatic logic [LANES*OUT_W-1:0] exp_q(input vec_t v);
`ifdef SFP_NORM_ROUND_EN
        return v.qr;
`else
        return v.q;
`endif
    endfunction

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k, s, bad_t, bad_a, bad_b;
        logic [DW-1:0] ea;
        logic [LANES*OUT_W-1:0] eq;
        @(negedge clk);
        check({v.name, ".in_ready"}, 96'(in_ready), 96'(1));
        st_t.delete(); st_a.delete(); st_b.delete();
        in_data  = v.e;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(k);
        check({v.name, ".latency"}, 96'(k), 96'(v.lat));
        check({v.name, ".starts"}, 96'(st_t.size()), 96'(v.nst));
        s = 0;
        for (int i = 0; i < LANES; i++) s += int'(v.e[i*ELEM_W +: ELEM_W]);
        bad_t = 0; bad_a = 0; bad_b = 0;
        for (int i = 0; i < st_t.size() && i < LANES; i++) begin
            ea = (DW'(v.e[i*ELEM_W +: ELEM_W]) << FRAC);
`ifdef SFP_NORM_ROUND_EN
            ea = ea + DW'(s / 2);
`endif
            if (i > 0 && st_t[i] - st_t[i-1] != 22) bad_t++;
            if (st_a[i] != ea) bad_a++;
            if (st_b[i] != DW'(s)) bad_b++;
        end
        if (v.nst > 0) begin
            check({v.name, ".start_spacing_errs"}, 96'(bad_t), 96'(0));
            check({v.name, ".div_a_errs"}, 96'(bad_a), 96'(0));
            check({v.name, ".div_b_errs"}, 96'(bad_b), 96'(0));
        end
        eq = exp_q(v);
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s.lane%0d", v.name, i),
                  96'(out_data[i*OUT_W +: OUT_W]), 96'(eq[i*OUT_W +: OUT_W]));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, ".out_valid_drop"}, 96'(out_valid), 96'(0));
        check({v.name, ".in_ready_back"}, 96'(in_ready), 96'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        logic [LANES*OUT_W-1:0] snap;

        set_vec(0, "all100", {8{11'd100}}, {8{9'd32}}, {8{9'd32}}, 177, 8);
        set_vec(1, "lane0max", {{7{11'd0}}, 11'd2047}, {{7{9'd0}}, 9'd256},
                {{7{9'd0}}, 9'd256}, 177, 8);
        set_vec(2, "zeros", '0, '0, '0, 1, 0);
        set_vec(3, "one_two", {{6{11'd0}}, 11'd2, 11'd1}, {{6{9'd0}}, 9'd170, 9'd85},
                {{6{9'd0}}, 9'd171, 9'd85}, 177, 8);
        set_vec(4, "three_one", {{6{11'd0}}, 11'd1, 11'd3}, {{6{9'd0}}, 9'd64, 9'd192},
                {{6{9'd0}}, 9'd64, 9'd192}, 177, 8);
        set_vec(5, "four_fives", {{4{11'd0}}, {4{11'd5}}}, {{4{9'd0}}, {4{9'd64}}},
                {{4{9'd0}}, {4{9'd64}}}, 177, 8);

        repeat (3) @(negedge clk);
        check("rst.in_ready", 96'(in_ready), 96'(1));
        check("rst.out_valid", 96'(out_valid), 96'(0));
        check("rst.div_start", 96'(div_start), 96'(0));
        check("rst.div_a", 96'(div_a), 96'(0));
        check("rst.div_b", 96'(div_b), 96'(0));
        check("rst.out_data", 96'(out_data), 96'(0));
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) run_vec(vt[v]);

        // Held DONE: result stable, input ignored, accept right after out_ready.
        @(negedge clk);
        in_data  = vt[3].e;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = vt[0].e;
        wait_out(k);
        check("hold.latency", 96'(k), 96'(177));
        snap = out_data;
        check("hold.result", 96'(snap), 96'(exp_q(vt[3])));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_data != snap || in_ready || !out_valid) bad++;
        end
        check("hold.stable_errs", 96'(bad), 96'(0));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold.in_ready_idle", 96'(in_ready), 96'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold.accepted", 96'(in_ready), 96'(0));
        wait_out(k);
        check("hold.next_latency", 96'(k), 96'(177));
        check("hold.next_result", 96'(out_data), 96'(exp_q(vt[0])));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse while waiting on lane 3's divide.
        st_t.delete(); st_a.delete(); st_b.delete();
        in_data  = vt[0].e;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (st_t.size() < 4 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("midrst.reached_lane3", 96'(st_t.size()), 96'(4));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.in_ready", 96'(in_ready), 96'(1));
        check("midrst.out_valid", 96'(out_valid), 96'(0));
        check("midrst.div_start", 96'(div_start), 96'(0));
        check("midrst.out_data", 96'(out_data), 96'(0));
        run_vec(vt[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
